// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Memory-side responder for the CPU data-access port. Serves
//               byte/half/word loads and stores from an internal little-endian
//               byte array with a fixed multi-cycle latency, holding BUSYWAIT
//               high for the whole access so the MA stage stalls behind it.
// Ports       : CLK       - clock, all state updates on rising edge
//               RESET     - synchronous active-low reset
//               READ      - load request  (00 none, 01 byte, 10 half, 11 word)
//               WRITE     - store request (00 none, 01 byte, 10 half, 11 word)
//               ADDR      - byte address (upper bits wrap)
//               DATA_IN   - store data, byte/half taken from low bits
//               DATA_OUT  - registered load data, zero-extended
//               BUSYWAIT  - high while a request is pending
//               MISALIGN  - one-cycle pulse in DONE for a dropped misaligned access
//               RD_COUNT  - completed aligned loads  (DMEM_STATS_EN only)
//               WR_COUNT  - completed aligned stores (DMEM_STATS_EN only)
// Options     : define DMEM_STATS_EN to add the RD_COUNT/WR_COUNT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [1:0]  READ,
    input  logic [1:0]  WRITE,
    input  logic [31:0] ADDR,
    input  logic [31:0] DATA_IN,
    output logic [31:0] DATA_OUT,
    output logic        BUSYWAIT,
    output logic        MISALIGN
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] RD_COUNT,
    output logic [31:0] WR_COUNT
`endif
);

    localparam logic [3:0] c_lat_m1 = 4'(LATENCY - 1);
    localparam bit         c_single = (LATENCY == 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_cnt;
    logic [1:0]              r_read;
    logic [1:0]              r_write;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [31:0]             r_wdata;

    logic [7:0]              r_mem [0:(2**ADDR_WIDTH)-1];

    logic                    w_req;
    logic                    w_capture;
    logic                    w_access;
    logic [1:0]              w_acc_read;
    logic [1:0]              w_acc_write;
    logic [ADDR_WIDTH-1:0]   w_acc_addr;
    logic [31:0]             w_acc_wdata;
    logic [ADDR_WIDTH-3:0]   w_word_idx;
    logic [1:0]              w_size;
    logic                    w_is_store;
    logic                    w_misalign;
    logic                    w_do_store;
    logic                    w_do_load;
    logic [3:0]              w_lane_we;
    logic [3:0][7:0]         w_lane_data;
    logic [3:0][7:0]         w_rd_lanes;
    logic [31:0]             w_load_val;

    // Address bits above the decoded range are intentionally ignored (wrap).
    generate
        if (ADDR_WIDTH < 32) begin : g_addr_hi
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^ADDR[31:ADDR_WIDTH];
        end
    endgenerate

    assign w_req     = (READ != 2'b00) || (WRITE != 2'b00);
    assign w_capture = (r_state == S_IDLE) && w_req;

    // With LATENCY==1 the access happens on the accept edge, so the live
    // inputs are the operands; otherwise the captured copies are used.
    assign w_access = RESET &&
                      ((c_single && w_capture) ||
                       ((r_state == S_BUSY) && (r_cnt == 4'd1)));

    assign w_acc_read  = (r_state == S_IDLE) ? READ                   : r_read;
    assign w_acc_write = (r_state == S_IDLE) ? WRITE                  : r_write;
    assign w_acc_addr  = (r_state == S_IDLE) ? ADDR[ADDR_WIDTH-1:0]   : r_addr;
    assign w_acc_wdata = (r_state == S_IDLE) ? DATA_IN                : r_wdata;
    assign w_word_idx  = w_acc_addr[ADDR_WIDTH-1:2];

    // A store wins over a simultaneous load, so alignment follows its size.
    assign w_is_store = (w_acc_write != 2'b00);
    assign w_size     = w_is_store ? w_acc_write : w_acc_read;
    assign w_misalign = ((w_size == 2'b10) && w_acc_addr[0]) ||
                        ((w_size == 2'b11) && (w_acc_addr[1:0] != 2'b00));

    assign w_do_store = w_access && w_is_store && !w_misalign;
    assign w_do_load  = w_access && !w_is_store && (w_acc_read != 2'b00) && !w_misalign;

    // Byte-lane enables and lane data for stores.
    always_comb begin
        w_lane_we   = 4'b0000;
        w_lane_data = w_acc_wdata;
        case (w_acc_write)
            2'b01: begin
                w_lane_we[w_acc_addr[1:0]]   = 1'b1;
                w_lane_data[w_acc_addr[1:0]] = w_acc_wdata[7:0];
            end
            2'b10: begin
                if (w_acc_addr[1]) begin
                    w_lane_we[3:2]  = 2'b11;
                    w_lane_data[2]  = w_acc_wdata[7:0];
                    w_lane_data[3]  = w_acc_wdata[15:8];
                end else begin
                    w_lane_we[1:0]  = 2'b11;
                end
            end
            2'b11:   w_lane_we = 4'b1111;
            default: w_lane_we = 4'b0000;
        endcase
    end

    always_comb begin
        w_rd_lanes = '0;
        for (int k = 0; k < 4; k++) begin
            w_rd_lanes[k] = r_mem[{w_word_idx, 2'(k)}];
        end
    end

    // Right-justify and zero-extend sub-word loads.
    always_comb begin
        w_load_val = 32'h0;
        case (w_acc_read)
            2'b01:   w_load_val = {24'h0, w_rd_lanes[w_acc_addr[1:0]]};
            2'b10:   w_load_val = w_acc_addr[1] ? {16'h0, w_rd_lanes[3], w_rd_lanes[2]}
                                                : {16'h0, w_rd_lanes[1], w_rd_lanes[0]};
            2'b11:   w_load_val = w_rd_lanes;
            default: w_load_val = 32'h0;
        endcase
    end

    // Array contents survive reset; w_access is already gated by RESET so an
    // aborted store never commits.
    always_ff @(posedge CLK) begin
        for (int k = 0; k < 4; k++) begin
            if (w_do_store && w_lane_we[k]) begin
                r_mem[{w_word_idx, 2'(k)}] <= w_lane_data[k];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        BUSYWAIT    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    BUSYWAIT    = 1'b1;
                    w_state_nxt = c_single ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                BUSYWAIT = 1'b1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_DONE;
                end
            end
            // One dead cycle so a request still held by the stalled CPU is
            // not executed twice.
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_cnt    <= 4'd0;
            r_read   <= 2'b00;
            r_write  <= 2'b00;
            r_addr   <= '0;
            r_wdata  <= 32'h0;
            DATA_OUT <= 32'h0;
            MISALIGN <= 1'b0;
        end else begin
            if (w_capture) begin
                r_read  <= READ;
                r_write <= WRITE;
                r_addr  <= ADDR[ADDR_WIDTH-1:0];
                r_wdata <= DATA_IN;
                r_cnt   <= c_lat_m1;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - 4'd1;
            end
            MISALIGN <= w_access && w_misalign;
            if (w_do_load) begin
                DATA_OUT <= w_load_val;
            end
        end
    end

`ifdef DMEM_STATS_EN
    logic [31:0] r_rd_count;
    logic [31:0] r_wr_count;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_rd_count <= 32'h0;
            r_wr_count <= 32'h0;
        end else begin
            if (w_do_load) begin
                r_rd_count <= r_rd_count + 32'd1;
            end
            if (w_do_store) begin
                r_wr_count <= r_wr_count + 32'd1;
            end
        end
    end

    assign RD_COUNT = r_rd_count;
    assign WR_COUNT = r_wr_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Directed self-checking bench for data_mem_responder
//               (ADDR_WIDTH=10, LATENCY=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic        CLK;
    logic        RESET;
    logic [1:0]  READ;
    logic [1:0]  WRITE;
    logic [31:0] ADDR;
    logic [31:0] DATA_IN;
    logic [31:0] DATA_OUT;
    logic        BUSYWAIT;
    logic        MISALIGN;

    int n_total = 0;
    int n_bad   = 0;

    int          nb;
    logic [31:0] q;
    logic        m;
    logic [7:0]  pat;

    data_mem_responder #(
        .ADDR_WIDTH (10),
        .LATENCY    (3)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .READ     (READ),
        .WRITE    (WRITE),
        .ADDR     (ADDR),
        .DATA_IN  (DATA_IN),
        .DATA_OUT (DATA_OUT),
        .BUSYWAIT (BUSYWAIT),
        .MISALIGN (MISALIGN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request starting in an IDLE cycle, hold it while BUSYWAIT is
    // high, sample outputs in the DONE cycle, then release it.
    task automatic do_acc(input logic [1:0] r, input logic [1:0] w,
                          input logic [31:0] a, input logic [31:0] d,
                          output int nbusy, output logic [31:0] dq, output logic dm);
        READ    = r;
        WRITE   = w;
        ADDR    = a;
        DATA_IN = d;
        nbusy   = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (BUSYWAIT) nbusy++;
            else break;
        end
        dq    = DATA_OUT;
        dm    = MISALIGN;
        READ  = 2'b00;
        WRITE = 2'b00;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET   = 1'b0;
        READ    = 2'b00;
        WRITE   = 2'b00;
        ADDR    = 32'h0;
        DATA_IN = 32'h0;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("reset_dout", DATA_OUT, 32'h0);
        chk("reset_misalign", {31'h0, MISALIGN}, 32'h0);
        chk("reset_busy", {31'h0, BUSYWAIT}, 32'h0);
        @(posedge CLK); #1;
        RESET = 1'b1;

        // Seed address 0 and make DATA_OUT non-zero before the reset-hold step.
        do_acc(2'b00, 2'b11, 32'h0, 32'h1111_1111, nb, q, m);
        chk("seed_busy", nb, 3);
        do_acc(2'b11, 2'b00, 32'h0, 32'h0, nb, q, m);
        chk("seed_load", q, 32'h1111_1111);

        // Reset held for two edges with a store request present.
        RESET   = 1'b0;
        WRITE   = 2'b11;
        ADDR    = 32'h0;
        DATA_IN = 32'h1234_5678;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("rsthold_dout", DATA_OUT, 32'h0);
        @(posedge CLK); #1;
        RESET = 1'b1;
        WRITE = 2'b00;
        do_acc(2'b11, 2'b00, 32'h0, 32'h0, nb, q, m);
        chk("rsthold_nostore", q, 32'h1111_1111);

        // Word store/load.
        do_acc(2'b00, 2'b11, 32'h10, 32'hDEAD_BEEF, nb, q, m);
        chk("wst_busy", nb, 3);
        chk("wst_mis", {31'h0, m}, 32'h0);
        do_acc(2'b11, 2'b00, 32'h10, 32'h0, nb, q, m);
        chk("wld_busy", nb, 3);
        chk("wld_data", q, 32'hDEAD_BEEF);

        // Sub-word lanes.
        do_acc(2'b00, 2'b01, 32'h13, 32'hFFFF_FFAA, nb, q, m);
        chk("bst_busy", nb, 3);
        do_acc(2'b11, 2'b00, 32'h10, 32'h0, nb, q, m);
        chk("lane_word", q, 32'hAAAD_BEEF);
        do_acc(2'b01, 2'b00, 32'h11, 32'h0, nb, q, m);
        chk("lane_byte", q, 32'h0000_00BE);
        do_acc(2'b10, 2'b00, 32'h12, 32'h0, nb, q, m);
        chk("lane_half", q, 32'h0000_AAAD);

        // Misalignment.
        do_acc(2'b00, 2'b11, 32'h12, 32'h5555_5555, nb, q, m);
        chk("mis_wst_busy", nb, 3);
        chk("mis_wst_pulse", {31'h0, m}, 32'h1);
        chk("mis_wst_dout", q, 32'h0000_AAAD);
        @(negedge CLK);
        chk("mis_pulse_end", {31'h0, MISALIGN}, 32'h0);
        @(posedge CLK); #1;
        do_acc(2'b11, 2'b00, 32'h10, 32'h0, nb, q, m);
        chk("mis_nowrite", q, 32'hAAAD_BEEF);
        chk("mis_aligned_flag", {31'h0, m}, 32'h0);
        do_acc(2'b10, 2'b00, 32'h11, 32'h0, nb, q, m);
        chk("mis_hld_busy", nb, 3);
        chk("mis_hld_pulse", {31'h0, m}, 32'h1);
        chk("mis_hld_dout", q, 32'hAAAD_BEEF);

        // Reset during the second BUSY cycle aborts the store.
        do_acc(2'b00, 2'b11, 32'h20, 32'h0, nb, q, m);
        READ    = 2'b00;
        WRITE   = 2'b11;
        ADDR    = 32'h20;
        DATA_IN = 32'hCAFE_F00D;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        WRITE = 2'b00;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("abort_busy", {31'h0, BUSYWAIT}, 32'h0);
        chk("abort_dout", DATA_OUT, 32'h0);
        RESET = 1'b1;
        @(posedge CLK); #1;
        do_acc(2'b11, 2'b00, 32'h20, 32'h0, nb, q, m);
        chk("abort_nostore", q, 32'h0);

        // Address wrap, then a load held through DONE into the next IDLE.
        do_acc(2'b00, 2'b11, 32'h400, 32'h0102_0304, nb, q, m);
        READ = 2'b11;
        ADDR = 32'h0;
        pat  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            pat = {pat[6:0], BUSYWAIT};
            if (i == 3) chk("wrap_load", DATA_OUT, 32'h0102_0304);
        end
        READ = 2'b00;
        @(posedge CLK); #1;
        chk("held_pattern", {24'h0, pat}, 32'h0000_00EE);

        // Half store lanes and store-wins on simultaneous read+write.
        do_acc(2'b00, 2'b11, 32'h30, 32'h0, nb, q, m);
        do_acc(2'b00, 2'b10, 32'h32, 32'h9999_BBCC, nb, q, m);
        do_acc(2'b11, 2'b00, 32'h30, 32'h0, nb, q, m);
        chk("hst_word", q, 32'hBBCC_0000);
        do_acc(2'b10, 2'b00, 32'h30, 32'h0, nb, q, m);
        chk("hld_low", q, 32'h0);
        do_acc(2'b11, 2'b11, 32'h30, 32'h7777_7777, nb, q, m);
        chk("both_dout", q, 32'h0);
        do_acc(2'b11, 2'b00, 32'h30, 32'h0, nb, q, m);
        chk("both_store", q, 32'h7777_7777);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
